// File: rtl/dijkstra_path_tracer.sv
// dijkstra_path_tracer: walks the prev[] table left by DijkstraTop and streams the path destination-first
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE 255
`endif

module dijkstra_path_tracer #(
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] destination,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [MADDR_WIDTH-1:0] base_address,
    output logic                   mem_read_enable,
    input  logic                   mem_read_ready,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    output logic [INDEX_WIDTH-1:0] path_node,
    output logic                   path_valid,
    input  logic                   path_ready,
    output logic                   path_last,
    output logic [INDEX_WIDTH-1:0] path_length,
    output logic                   path_found,
    output logic                   ready
);
    localparam logic [INDEX_WIDTH-1:0] NPN = INDEX_WIDTH'(`NO_PREVIOUS_NODE);
    localparam logic [INDEX_WIDTH-1:0] NMAX = INDEX_WIDTH'(MAX_NODES);
    localparam logic [MADDR_WIDTH-1:0] STRIDE = MADDR_WIDTH'(MADDR_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, EMIT, READ_REQ, READ_WAIT, RELEASE, DONE} state_t;

    state_t                 state, state_nx;
    logic [INDEX_WIDTH-1:0] src, n, cur, prev_node;
    logic [MADDR_WIDTH-1:0] base;
    logic [INDEX_WIDTH:0]   count;
    logic                   en_q, abort, own, start, at_src, at_limit, bad_prev;
    logic [MDATA_WIDTH-1:0] unused_data;

    assign unused_data = mem_read_data;
    assign prev_node   = mem_read_data[INDEX_WIDTH-1:0];
    assign start       = enable && !en_q && (state == IDLE || state == DONE);
    assign at_src      = cur == src;
    assign at_limit    = count + 1'b1 == {1'b0, n};
    assign bad_prev    = prev_node == NPN || prev_node >= n;
    assign path_node   = cur;

    // The bus is only driven while a prev[] read is outstanding; otherwise it floats for other masters
    assign mem_read_enable = own ? 1'b1 : 1'bz;
    assign mem_addr = own ? base + (MADDR_WIDTH'(n) * MADDR_WIDTH'(n) + MADDR_WIDTH'(cur)) * STRIDE
                          : {MADDR_WIDTH{1'bz}};

    // Walk sequencing: next state plus stream, bus-ownership and completion outputs
    always_comb begin
        state_nx   = state;
        path_valid = 1'b0;
        path_last  = 1'b0;
        own        = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE:      state_nx = start ? EMIT : IDLE;
            EMIT: begin
                path_valid = 1'b1;
                path_last  = at_src || at_limit;
                state_nx   = !path_ready ? EMIT : (at_src || at_limit) ? DONE : READ_REQ;
            end
            READ_REQ: begin
                own      = 1'b1;
                state_nx = READ_WAIT;
            end
            READ_WAIT: begin
                own      = 1'b1;
                state_nx = mem_read_ready ? RELEASE : READ_WAIT;
            end
            RELEASE:   state_nx = abort ? DONE : EMIT;
            DONE: begin
                ready    = 1'b1;
                state_nx = start ? EMIT : DONE;
            end
            default:   state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Walk context: latched request, current node, beat count and result flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_q        <= 1'b0;
            src         <= '0;
            n           <= '0;
            base        <= '0;
            cur         <= '0;
            count       <= '0;
            path_length <= '0;
            path_found  <= 1'b0;
            abort       <= 1'b0;
        end else begin
            en_q <= enable;
            if (start) begin
                src         <= source;
                n           <= number_of_nodes > NMAX ? NMAX : number_of_nodes;
                base        <= base_address;
                cur         <= destination;
                count       <= '0;
                path_length <= '0;
                path_found  <= 1'b0;
                abort       <= 1'b0;
            end
            if (state == EMIT && path_ready) begin
                count      <= count + 1'b1;
                path_found <= at_src;
            end
            if (state == READ_WAIT && mem_read_ready) begin
                if (bad_prev) begin
                    abort <= 1'b1;
                end else begin
                    cur         <= prev_node;
                    path_length <= path_length + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dijkstra_path_tracer.sv
// tb_dijkstra_path_tracer: table vectors, reset corner case and randomized walks against a path model
module tb_dijkstra_path_tracer;
    localparam logic [7:0] NPN = 8'hFF;

    logic        clock = 0, reset = 0, enable = 0, path_ready = 0;
    logic [7:0]  source = 0, destination = 0, number_of_nodes = 0;
    logic [31:0] base_address = 0;
    logic        mem_read_ready = 0;
    logic [31:0] mem_read_data = 0;
    wire         mem_read_enable;
    wire  [31:0] mem_addr;
    logic [7:0]  path_node, path_length;
    logic        path_valid, path_last, path_found, ready;

    dijkstra_path_tracer #(.MADDR_WIDTH(32), .MDATA_WIDTH(32), .MAX_NODES(16), .INDEX_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .source(source), .destination(destination),
        .number_of_nodes(number_of_nodes), .base_address(base_address),
        .mem_read_enable(mem_read_enable), .mem_read_ready(mem_read_ready), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .path_node(path_node), .path_valid(path_valid),
        .path_ready(path_ready), .path_last(path_last), .path_length(path_length),
        .path_found(path_found), .ready(ready)
    );

    always #5 clock = ~clock;

    int         total = 0, bad = 0;
    logic [7:0] prev_mem [16];
    int         lat = 0, cnt = 0;
    bit         lat_rand = 0, saw_bus = 0;
    logic [7:0] got_node [$], exp_node [$];
    bit         got_last [$];
    logic [7:0] exp_len;
    bit         exp_found, exp_last_end;

    typedef struct {
        logic [7:0]       s, d, n;
        logic [3:0][7:0]  p;
        int               mode;
        int               cnt;
        logic [3:0][7:0]  nodes;
        bit               last_end;
        logic [7:0]       len;
        bit               found;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // BlockRam responder: decodes the prev[] index from the address and answers after a latency
    always @(negedge clock) begin
        logic [31:0] off, idx;
        if (mem_read_enable !== 1'b1) begin
            mem_read_ready = 0;
            cnt = lat_rand ? int'($urandom_range(0, 3)) : lat;
        end else begin
            saw_bus = 1;
            if (!mem_read_ready) begin
                if (cnt == 0) begin
                    off = mem_addr - base_address;
                    idx = off / 4 - 32'(number_of_nodes) * 32'(number_of_nodes);
                    chk("addr_align", off % 4, 0);
                    chk("addr_range", 32'(idx < 32'(number_of_nodes)), 1);
                    mem_read_data = {24'($urandom), prev_mem[idx[3:0]]};
                    mem_read_ready = 1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Reference path: follow prev[] from destination until source, a dead entry, or N beats
    task automatic model(input logic [7:0] s, d, nn);
        logic [7:0] c, p;
        c = d;
        exp_len = 0;
        exp_found = 0;
        exp_last_end = 0;
        exp_node.delete();
        while (1) begin
            exp_node.push_back(c);
            if (c == s) begin exp_found = 1; exp_last_end = 1; break; end
            if (exp_node.size() == int'(nn)) begin exp_last_end = 1; break; end
            p = prev_mem[c[3:0]];
            if (p == NPN || p >= nn) break;
            c = p;
            exp_len++;
        end
    endtask

    task automatic walk(input logic [7:0] s, d, nn, input int mode);
        int k, tog;
        bit stalled;
        logic [7:0] held;
        source = s;
        destination = d;
        number_of_nodes = nn;
        got_node.delete();
        got_last.delete();
        @(negedge clock);
        saw_bus = 0;
        enable = 1;
        @(negedge clock);
        enable = 0;
        k = 0;
        tog = 0;
        stalled = 0;
        held = 0;
        while (ready !== 1'b1 && k < 3000) begin
            if (stalled) begin
                chk("stall_valid", 32'(path_valid), 1);
                chk("stall_node", 32'(path_node), 32'(held));
            end
            path_ready = mode == 0 ? 1'b1 : mode == 1 ? tog[0] : 1'($urandom_range(0, 1));
            tog++;
            if (path_valid && path_ready) begin
                got_node.push_back(path_node);
                got_last.push_back(path_last);
                stalled = 0;
            end else if (path_valid) begin
                stalled = 1;
                held = path_node;
            end
            @(negedge clock);
            k++;
        end
        chk("walk_terminates", 32'(k < 3000), 1);
        chk("valid_low_when_done", 32'(path_valid), 0);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_beats"}, got_node.size(), exp_node.size());
        for (int i = 0; i < got_node.size() && i < exp_node.size(); i++) begin
            chk({tag, "_node"}, 32'(got_node[i]), 32'(exp_node[i]));
            chk({tag, "_last"}, 32'(got_last[i]), 32'(i == exp_node.size() - 1 && exp_last_end));
        end
        chk({tag, "_length"}, 32'(path_length), 32'(exp_len));
        chk({tag, "_found"}, 32'(path_found), 32'(exp_found));
        chk({tag, "_ready"}, 32'(ready), 1);
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 16; i++) prev_mem[i] = i < 4 ? v.p[i] : NPN;
        exp_node.delete();
        for (int i = 0; i < v.cnt; i++) exp_node.push_back(v.nodes[i]);
        exp_len = v.len;
        exp_found = v.found;
        exp_last_end = v.last_end;
    endtask

    task automatic wait_bus(output bit ok);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (mem_read_enable === 1'b1) begin ok = 1; break; end
            @(negedge clock);
        end
    endtask

    vec_t vecs [5];

    initial begin
        bit ok;
        logic [7:0] nn, s, d;
        // prev[] packed as {p3,p2,p1,p0}; expected nodes packed as {n3,n2,n1,n0}
        vecs[0] = '{s:0, d:3, n:4, p:{8'd2, 8'd1, 8'd0, NPN}, mode:0, cnt:4,
                    nodes:{8'd0, 8'd1, 8'd2, 8'd3}, last_end:1, len:3, found:1};
        vecs[1] = '{s:2, d:2, n:4, p:{8'd2, 8'd1, 8'd0, NPN}, mode:0, cnt:1,
                    nodes:{8'd0, 8'd0, 8'd0, 8'd2}, last_end:1, len:0, found:1};
        vecs[2] = '{s:0, d:3, n:4, p:{NPN, 8'd1, 8'd0, NPN}, mode:0, cnt:1,
                    nodes:{8'd0, 8'd0, 8'd0, 8'd3}, last_end:0, len:0, found:0};
        vecs[3] = '{s:0, d:3, n:4, p:{8'd2, 8'd1, 8'd0, NPN}, mode:1, cnt:4,
                    nodes:{8'd0, 8'd1, 8'd2, 8'd3}, last_end:1, len:3, found:1};
        vecs[4] = '{s:0, d:2, n:4, p:{NPN, 8'd1, 8'd2, NPN}, mode:0, cnt:4,
                    nodes:{8'd1, 8'd2, 8'd1, 8'd2}, last_end:1, len:3, found:0};

        base_address = 32'h0000_1000;
        #12;
        chk("rst_valid", 32'(path_valid), 0);
        chk("rst_last", 32'(path_last), 0);
        chk("rst_node", 32'(path_node), 0);
        chk("rst_length", 32'(path_length), 0);
        chk("rst_found", 32'(path_found), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_bus", 32'(mem_read_enable === 1'b1), 0);
        @(negedge clock);
        reset = 1;

        foreach (vecs[i]) begin
            load_vec(vecs[i]);
            lat = int'($urandom_range(0, 3));
            walk(vecs[i].s, vecs[i].d, vecs[i].n, vecs[i].mode);
            compare($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_bus_used", i), 32'(saw_bus), 32'(vecs[i].s != vecs[i].d));
            if (vecs[i].mode == 1) repeat (5) @(negedge clock);
        end

        // Reset asserted while the second prev[] read is waiting on a slow BlockRam
        load_vec(vecs[0]);
        lat = 6;
        path_ready = 1;
        source = 0;
        destination = 3;
        number_of_nodes = 4;
        @(negedge clock);
        enable = 1;
        @(negedge clock);
        enable = 0;
        wait_bus(ok);
        chk("rst_wait_bus1", 32'(ok), 1);
        for (int k = 0; k < 300 && mem_read_enable === 1'b1; k++) @(negedge clock);
        wait_bus(ok);
        chk("rst_wait_bus2", 32'(ok), 1);
        @(negedge clock);
        chk("rst_mid_length_before", 32'(path_length), 1);
        #2 reset = 0;
        #1;
        chk("rst_mid_valid", 32'(path_valid), 0);
        chk("rst_mid_node", 32'(path_node), 0);
        chk("rst_mid_length", 32'(path_length), 0);
        chk("rst_mid_found", 32'(path_found), 0);
        chk("rst_mid_ready", 32'(ready), 0);
        chk("rst_mid_bus", 32'(mem_read_enable === 1'b1), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        lat = 1;
        walk(0, 3, 4, 0);
        compare("rerun");

        // Randomized graphs against the reference path model
        lat_rand = 1;
        for (int t = 0; t < 40; t++) begin
            nn = 8'($urandom_range(1, 8));
            for (int i = 0; i < 16; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                prev_mem[i] = r < 2 ? NPN : r < 3 ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, int'(nn) - 1));
            end
            s = 8'($urandom_range(0, int'(nn) - 1));
            d = 8'($urandom_range(0, int'(nn) - 1));
            base_address = {$urandom} & 32'hFFFF_FFFC;
            model(s, d, nn);
            walk(s, d, nn, 2);
            compare($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
